div_16: RTL

Unsigned iterative restoring divider, the sequential inverse companion to the team's 16-bit carry-lookahead adder datapath. It takes a dividend/divisor pair over a valid/ready handshake and produces one quotient bit per cycle using a 17-bit trial subtraction. It returns quotient, remainder and a divide-by-zero flag over a second valid/ready handshake. It sits beside the adder in the integer execute path as the multi-cycle DIV/REM unit.

---
 rtl/div_pkg.sv | 14 +
 rtl/div_sub_17.sv | 50 +++++
 rtl/div_16.sv | 122 ++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM states and the
// divide-by-zero quotient fill value.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Each quotient bit is set to this value on divide-by-zero (all ones).
  localparam logic DIV_ZERO_FILL = 1'b1;

endpackage

// File: rtl/div_sub_17.sv
// (W)-bit subtractor a + ~b + 1 using 4-bit carry-lookahead groups.
// Outputs the difference and a borrow flag (no carry out of the top bit).
module div_sub_17 #(
  parameter int W = 17
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  localparam int NG = (W + 3) / 4;

  logic [W-1:0]  b_n;
  logic [W-1:0]  g;
  logic [W-1:0]  p;
  logic [W:0]    c;
  logic [NG-1:0] grp_c;
  logic          grp_g;
  logic          grp_p;

  // Group generate/propagate give each group's carry-in; bits ripple within a group.
  always_comb begin
    b_n      = ~b;
    g        = a & b_n;
    p        = a ^ b_n;
    grp_c    = '0;
    grp_c[0] = 1'b1;
    grp_g    = 1'b0;
    grp_p    = 1'b0;
    for (int n = 0; n < NG - 1; n++) begin
      grp_g = 1'b0;
      grp_p = 1'b1;
      for (int k = 0; k < 4; k++) begin
        grp_g = g[4*n+k] | (p[4*n+k] & grp_g);
        grp_p = grp_p & p[4*n+k];
      end
      grp_c[n+1] = grp_g | (grp_p & grp_c[n]);
    end
    c = '0;
    for (int i = 0; i < W; i++) begin
      if (i % 4 == 0) c[i] = grp_c[i/4];
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign diff   = p ^ c[W-1:0];
  assign borrow = ~c[W];

endmodule

// File: rtl/div_16.sv
// Unsigned restoring divider: one quotient bit per cycle, valid/ready on
// both the operand and result sides, divide-by-zero flagged in one cycle.
module div_16
  import div_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   sub_diff;
  logic             sub_borrow;
  logic             take;

  assign trial = {r_q, q_q[WIDTH-1]};

  div_sub_17 #(.W(WIDTH + 1)) u_sub (
    .a      (trial),
    .b      ({1'b0, divisor_q}),
    .diff   (sub_diff),
    .borrow (sub_borrow)
  );

  // Trial never exceeds 2*divisor-1, so the borrow and the difference MSB always agree.
  assign take = ~(sub_diff[WIDTH] | sub_borrow);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    q_d         = q_q;
    r_d         = r_q;
    divisor_d   = divisor_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (divisor == '0) begin
            quotient_d  = {WIDTH{DIV_ZERO_FILL}};
            remainder_d = dividend;
            dbz_d       = 1'b1;
            state_d     = DONE;
          end else begin
            divisor_d = divisor;
            q_d       = dividend;
            r_d       = '0;
            count_d   = '0;
            state_d   = BUSY;
          end
        end
      end
      BUSY: begin
        q_d     = {q_q[WIDTH-2:0], take};
        r_d     = take ? sub_diff[WIDTH-1:0] : trial[WIDTH-1:0];
        count_d = count_q + 1'b1;
        if (count_q == LAST_ITER) begin
          quotient_d  = q_d;
          remainder_d = r_d;
          dbz_d       = 1'b0;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      q_q         <= '0;
      r_q         <= '0;
      divisor_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      q_q         <= q_d;
      r_q         <= r_d;
      divisor_q   <= divisor_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
